// File: rtl/keypad_entry.sv
// keypad_entry: builds a signed decimal operand from keypad presses.
// Up to six BCD digits are collected for the display, with an optional sign.
// Enter converts the BCD magnitude to binary with a 24-step reverse double-dabble
// and presents the result as a 32-bit two's-complement value.
// Optional feature macro: KEYPAD_SIGN_EN (sign toggle key and negative results).
module keypad_entry (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [23:0] BCD_I,
    output logic        sign,
    output logic        busy,
    output logic [31:0] value,
    output logic        value_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] KEY_SIGN  = 4'hA;
    localparam logic [3:0] KEY_BACK  = 4'hB;
    localparam logic [3:0] KEY_CLEAR = 4'hC;
    localparam logic [3:0] KEY_ENTER = 4'hD;

    localparam int         NUM_DIGITS = 6;
    localparam logic [4:0] LAST_STEP  = 5'd24;

    state_t      state_reg;
    logic [23:0] bcd_reg;
    logic [2:0]  count_reg;
    logic [47:0] shift_reg;
    logic [4:0]  step_reg;
    logic        busy_reg;
    logic [31:0] value_reg;
    logic        valid_reg;
    logic        sign_reg;

    // Key decode; only meaningful while idle and strobed.
    logic key_take;
    logic is_digit;
    logic is_back;
    logic is_clear;
    logic is_enter;
    logic is_sign;
    logic digits_full;
    logic digits_empty;
    logic conv_last;

    assign key_take     = key_valid && (state_reg == IDLE);
    assign is_digit     = key_take && (key_code <= 4'd9);
    assign is_back      = key_take && (key_code == KEY_BACK);
    assign is_clear     = key_take && (key_code == KEY_CLEAR);
    assign is_enter     = key_take && (key_code == KEY_ENTER);
    assign digits_full  = (count_reg == 3'(NUM_DIGITS));
    assign digits_empty = (count_reg == 3'd0);
    assign conv_last    = (state_reg == CONV) && (step_reg == LAST_STEP);

`ifdef KEYPAD_SIGN_EN
    assign is_sign = key_take && (key_code == KEY_SIGN);
`else
    assign is_sign = 1'b0;
`endif

    // One reverse double-dabble step: shift right, then pull each BCD nibble
    // that landed at 8 or above back down by 3 (undoing the x2 of decimal carry).
    logic [47:0] shifted;
    logic [47:0] dabbled;

    assign shifted       = {1'b0, shift_reg[47:1]};
    assign dabbled[23:0] = shifted[23:0];

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nibble_fix
            logic [3:0] nib;
            assign nib = shifted[24 + 4*gi +: 4];
            assign dabbled[24 + 4*gi +: 4] = (nib >= 4'd8) ? (nib - 4'd3) : nib;
        end
    endgenerate

    // Final magnitude sits in the low 24 bits once all steps are done.
    logic [31:0] magnitude;
    logic [31:0] result;

    assign magnitude = {8'h00, shift_reg[23:0]};

`ifdef KEYPAD_SIGN_EN
    // Negating a zero magnitude gives zero, so negative zero needs no special case.
    assign result = sign_reg ? (32'd0 - magnitude) : magnitude;
`else
    assign result = magnitude;
`endif

    // Digit buffer, digit count and the entry/conversion state machine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            bcd_reg   <= 24'h0;
            count_reg <= 3'd0;
            shift_reg <= 48'h0;
            step_reg  <= 5'd0;
            busy_reg  <= 1'b0;
            value_reg <= 32'h0;
            valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    valid_reg <= 1'b0;
                    if (is_digit && !digits_full) begin
                        bcd_reg   <= {bcd_reg[19:0], key_code};
                        count_reg <= count_reg + 3'd1;
                    end else if (is_back && !digits_empty) begin
                        bcd_reg   <= {4'h0, bcd_reg[23:4]};
                        count_reg <= count_reg - 3'd1;
                    end else if (is_clear) begin
                        bcd_reg   <= 24'h0;
                        count_reg <= 3'd0;
                    end else if (is_enter) begin
                        shift_reg <= {bcd_reg, 24'h0};
                        step_reg  <= 5'd0;
                        busy_reg  <= 1'b1;
                        state_reg <= CONV;
                    end
                end
                CONV: begin
                    // Steps 0..23 shift; the extra pass at 24 publishes the result
                    // so that the DONE cycle lines up with the valid pulse.
                    if (conv_last) begin
                        value_reg <= result;
                        valid_reg <= 1'b1;
                        bcd_reg   <= 24'h0;
                        count_reg <= 3'd0;
                        state_reg <= DONE;
                    end else begin
                        shift_reg <= dabbled;
                        step_reg  <= step_reg + 5'd1;
                    end
                end
                DONE: begin
                    valid_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

`ifdef KEYPAD_SIGN_EN
    // Sign flag: toggled by its key, dropped on clear and after each conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_reg <= 1'b0;
        end else if (is_sign) begin
            sign_reg <= ~sign_reg;
        end else if (is_clear || conv_last) begin
            sign_reg <= 1'b0;
        end
    end
`else
    assign sign_reg = 1'b0;
`endif

    assign BCD_I       = bcd_reg;
    assign sign        = sign_reg;
    assign busy        = busy_reg;
    assign value       = value_reg;
    assign value_valid = valid_reg;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: a decimal-number reference model tracks the entry and
// the conversion timeline; every negedge the DUT outputs are compared against it.
// Directed sequences pin the model with hand-computed values; a random phase follows.
module tb_keypad_entry;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic [23:0] BCD_I;
    logic        sign;
    logic        busy;
    logic [31:0] value;
    logic        value_valid;

    keypad_entry dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .BCD_I       (BCD_I),
        .sign        (sign),
        .busy        (busy),
        .value       (value),
        .value_valid (value_valid)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;
    int cyc = 0;
    int enter_cyc = 0;

`ifdef KEYPAD_SIGN_EN
    localparam bit SIGN_ON = 1'b1;
`else
    localparam bit SIGN_ON = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Reference model: the entry is an ordinary decimal integer.
    int          m_num;
    int          m_count;
    bit          m_sign;
    bit          m_busy;
    int          m_timer;
    logic [31:0] m_value;
    bit          m_valid;
    int          c_num;
    bit          c_sign;

    function automatic logic [23:0] to_bcd(input int n);
        logic [23:0] r;
        int          x;
        r = 24'h0;
        x = n;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Model update on each rising edge from the inputs present at that edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_num   <= 0;
            m_count <= 0;
            m_sign  <= 1'b0;
            m_busy  <= 1'b0;
            m_timer <= 0;
            m_value <= 32'h0;
            m_valid <= 1'b0;
            c_num   <= 0;
            c_sign  <= 1'b0;
        end else if (m_busy) begin
            m_timer <= m_timer + 1;
            m_valid <= (m_timer == 24);
            if (m_timer == 24) begin
                m_value <= (c_sign && SIGN_ON) ? 32'(-c_num) : 32'(c_num);
                m_num   <= 0;
                m_count <= 0;
                m_sign  <= 1'b0;
            end
            if (m_timer == 25) m_busy <= 1'b0;
        end else begin
            m_valid <= 1'b0;
            if (key_valid) begin
                if (key_code <= 4'd9) begin
                    if (m_count < 6) begin
                        m_num   <= m_num * 10 + int'(key_code);
                        m_count <= m_count + 1;
                    end
                end else if (key_code == 4'hA) begin
                    if (SIGN_ON) m_sign <= ~m_sign;
                end else if (key_code == 4'hB) begin
                    if (m_count > 0) begin
                        m_num   <= m_num / 10;
                        m_count <= m_count - 1;
                    end
                end else if (key_code == 4'hC) begin
                    m_num   <= 0;
                    m_count <= 0;
                    m_sign  <= 1'b0;
                end else if (key_code == 4'hD) begin
                    m_busy  <= 1'b1;
                    m_timer <= 0;
                    c_num   <= m_num;
                    c_sign  <= m_sign;
                end
            end
        end
    end

    // Compare process: every cycle out of reset, all outputs against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("bcd",   32'(BCD_I),       32'(to_bcd(m_num)));
            chk("sign",  32'(sign),        32'(m_sign));
            chk("busy",  32'(busy),        32'(m_busy));
            chk("value", value,            m_value);
            chk("valid", 32'(value_valid), 32'(m_valid));
        end
    end

    task automatic press(input logic [3:0] c);
        @(posedge clk);
        #1;
        key_valid = 1'b1;
        key_code  = c;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        if (c == 4'hD) enter_cyc = cyc;
        $display("key %h -> BCD_I=%h sign=%0d busy=%0d", c, BCD_I, sign, busy);
    endtask

    task automatic wait_valid(input string nm, input logic [31:0] exp, input bit chk_lat);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #1;
            if (value_valid) found = 1'b1;
        end
        if (!found) begin
            chk({nm, "_timeout"}, 32'd0, 32'd1);
        end else begin
            if (chk_lat) chk({nm, "_latency"}, 32'(cyc - enter_cyc), 32'd25);
            chk({nm, "_value"}, value, exp);
            $display("convert %s -> value=%h", nm, value);
        end
        @(posedge clk);
        #1;
        chk({nm, "_pulse"}, 32'(value_valid), 32'd0);
        chk({nm, "_cleared"}, 32'(BCD_I), 32'd0);
    endtask

    initial begin
        logic [31:0] neg_exp;
        int          r;

        // Reset state.
        #12;
        chk("rst_bcd",   32'(BCD_I),       32'd0);
        chk("rst_sign",  32'(sign),        32'd0);
        chk("rst_busy",  32'(busy),        32'd0);
        chk("rst_value", value,            32'd0);
        chk("rst_valid", 32'(value_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Six digits, exact latency and result.
        for (int d = 1; d <= 6; d++) press(4'(d));
        chk("six_bcd", 32'(BCD_I), 32'h00123456);
        press(4'hD);
        wait_valid("123456", 32'h0001E240, 1'b1);

        // Reset in the middle of a conversion.
        press(4'h1);
        press(4'h2);
        press(4'hD);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_bcd",   32'(BCD_I),       32'd0);
        chk("midrst_sign",  32'(sign),        32'd0);
        chk("midrst_busy",  32'(busy),        32'd0);
        chk("midrst_value", value,            32'd0);
        chk("midrst_valid", 32'(value_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (value_valid) chk("midrst_novalid", 32'(value_valid), 32'd0);
        end

        // Seventh digit ignored, maximum magnitude.
        repeat (6) press(4'h9);
        press(4'h7);
        chk("max_bcd", 32'(BCD_I), 32'h00999999);
        press(4'hD);
        wait_valid("999999", 32'h000F423F, 1'b1);

        // Sign toggle.
        press(4'h4);
        press(4'h2);
        press(4'hA);
        chk("neg_sign", 32'(sign), 32'(SIGN_ON));
        neg_exp = SIGN_ON ? 32'hFFFFFFD6 : 32'h0000002A;
        press(4'hD);
        wait_valid("neg42", neg_exp, 1'b1);
        chk("neg_sign_after", 32'(sign), 32'd0);

        // Editing keys.
        press(4'h7);
        press(4'h8);
        chk("edit_78", 32'(BCD_I), 32'h78);
        press(4'hB);
        chk("edit_7", 32'(BCD_I), 32'h7);
        press(4'hC);
        chk("edit_clr", 32'(BCD_I), 32'h0);
        press(4'h5);
        chk("edit_5", 32'(BCD_I), 32'h5);
        press(4'hB);
        chk("edit_b1", 32'(BCD_I), 32'h0);
        press(4'hB);
        chk("edit_b2", 32'(BCD_I), 32'h0);
        press(4'hD);
        wait_valid("edit0", 32'h0, 1'b1);

        // Key while busy is dropped.
        press(4'h1);
        press(4'hD);
        press(4'h3);
        wait_valid("drop", 32'h1, 1'b1);

        // Negative zero.
        press(4'hA);
        press(4'hD);
        wait_valid("negzero", 32'h0, 1'b1);

        // Random keys against the model.
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            key_valid = ($urandom_range(0, 2) == 0);
            r = $urandom_range(0, 99);
            if (r < 55)      key_code = 4'($urandom_range(0, 9));
            else if (r < 65) key_code = 4'hA;
            else if (r < 75) key_code = 4'hB;
            else if (r < 80) key_code = 4'hC;
            else if (r < 90) key_code = 4'hD;
            else             key_code = 4'($urandom_range(14, 15));
            if (key_valid && !busy) $display("rand key %h", key_code);
        end
        key_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
